// File: rtl/fpu_sched.sv
// FPU issue/completion scheduler: valid/ready issue, completion-slot reservation, tagged output
// FIFO and sticky exception flags. Define FPU_SCHED_EARLY_EXC_EN to retire FDIV/0 and SQRT(-x) early.
module fpu_sched #(
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned LAT_MUL   = 2,
  parameter int unsigned LAT_DIV   = 3,
  parameter int unsigned LAT_SQRT  = 2,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_op_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic             in_a_sign_i,
  input  logic             in_b_zero_i,
  input  logic [31:0]      fast_res_i,
  input  logic [4:0]       fast_exc_i,
  input  logic [31:0]      mul_res_i,
  input  logic [4:0]       mul_exc_i,
  input  logic [31:0]      ds_res_i,
  input  logic [4:0]       ds_exc_i,
  output logic             ds_start_o,
  output logic             ds_is_sqrt_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_res_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [4:0]       out_exc_o,
  input  logic             fsr_clr_i,
  output logic [4:0]       fsr_o,
  output logic             busy_o
);

  localparam int unsigned LMAX_MD = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int unsigned LMAX    = (LMAX_MD > LAT_SQRT) ? LMAX_MD : LAT_SQRT;
  localparam int unsigned LW      = $clog2(LMAX + 1);
  localparam int unsigned PTR_W   = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  localparam logic [3:0] OpFmul = 4'b0010;
  localparam logic [3:0] OpFdiv = 4'b0011;
  localparam logic [3:0] OpSqrt = 4'b0100;

  typedef enum logic {SrcMul, SrcDs} src_e;

  // Opcode decode
  logic [LW-1:0] op_lat;
  logic          op_slow;
  logic          op_ds;
  logic          op_fixed;
  logic [31:0]   fixed_res;
  logic [4:0]    fixed_exc;

`ifdef FPU_SCHED_EARLY_EXC_EN
  localparam logic [31:0] QnanRes = 32'h7FC0_0000;
`endif

  always_comb begin
    op_lat    = '0;
    op_slow   = 1'b0;
    op_ds     = 1'b0;
    op_fixed  = 1'b0;
    fixed_res = '0;
    fixed_exc = '0;
    case (in_op_i)
      OpFmul: begin
        op_lat  = LW'(LAT_MUL);
        op_slow = 1'b1;
      end
      OpFdiv: begin
`ifdef FPU_SCHED_EARLY_EXC_EN
        if (in_b_zero_i) begin
          op_fixed  = 1'b1;
          fixed_res = QnanRes;
          fixed_exc = 5'b11000;
        end else begin
          op_lat  = LW'(LAT_DIV);
          op_slow = 1'b1;
          op_ds   = 1'b1;
        end
`else
        op_lat  = LW'(LAT_DIV);
        op_slow = 1'b1;
        op_ds   = 1'b1;
`endif
      end
      OpSqrt: begin
`ifdef FPU_SCHED_EARLY_EXC_EN
        if (in_a_sign_i) begin
          op_fixed  = 1'b1;
          fixed_res = QnanRes;
          fixed_exc = 5'b10000;
        end else begin
          op_lat  = LW'(LAT_SQRT);
          op_slow = 1'b1;
          op_ds   = 1'b1;
        end
`else
        op_lat  = LW'(LAT_SQRT);
        op_slow = 1'b1;
        op_ds   = 1'b1;
`endif
      end
      4'b1101, 4'b1110, 4'b1111: begin
        op_fixed  = 1'b1;
        fixed_exc = 5'b10000;
      end
      default: ;
    endcase
  end

`ifndef FPU_SCHED_EARLY_EXC_EN
  logic unused_early;
  assign unused_early = in_a_sign_i ^ in_b_zero_i;
`endif

  // Reservation slots: bit k = FIFO write booked k cycles from now
  logic [LMAX:0]    slot_q, slot_d;
  src_e             slot_src_q [LMAX+1];
  src_e             slot_src_d [LMAX+1];
  logic [TAG_W-1:0] slot_tag_q [LMAX+1];
  logic [TAG_W-1:0] slot_tag_d [LMAX+1];
  logic             ds_busy_q, ds_busy_d;

  // Output FIFO state
  logic [31:0]      mem_res_q [OUT_DEPTH];
  logic [TAG_W-1:0] mem_tag_q [OUT_DEPTH];
  logic [4:0]       mem_exc_q [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       fsr_q, fsr_d;

  logic             ds_sample;
  logic             ds_free;
  int unsigned      booked;
  logic             credit_ok;
  logic             issue;
  logic             pop;
  logic             wr_en;
  logic [31:0]      wr_res;
  logic [TAG_W-1:0] wr_tag;
  logic [4:0]       wr_exc;

  assign ds_sample = slot_q[0] & (slot_src_q[0] == SrcDs);
  // The unit frees up in the cycle its result is sampled.
  assign ds_free   = ~ds_busy_q | ds_sample;

  always_comb begin
    booked = 0;
    for (int k = 0; k <= int'(LMAX); k++) begin
      booked += 32'(slot_q[k]);
    end
  end

  assign credit_ok  = (32'(count_q) + booked) < OUT_DEPTH;
  assign in_ready_o = rst_ni & ~slot_q[op_lat] & credit_ok & (~op_ds | ds_free);
  assign issue      = in_valid_i & in_ready_o;

  assign ds_start_o   = issue & op_ds;
  assign ds_is_sqrt_o = ds_start_o & (in_op_i == OpSqrt);

  always_comb begin
    for (int k = 0; k < int'(LMAX); k++) begin
      slot_d[k]     = slot_q[k+1];
      slot_src_d[k] = slot_src_q[k+1];
      slot_tag_d[k] = slot_tag_q[k+1];
    end
    slot_d[LMAX]     = 1'b0;
    slot_src_d[LMAX] = SrcMul;
    slot_tag_d[LMAX] = '0;
    if (issue && op_slow) begin
      slot_d[op_lat - LW'(1)]     = 1'b1;
      slot_src_d[op_lat - LW'(1)] = op_ds ? SrcDs : SrcMul;
      slot_tag_d[op_lat - LW'(1)] = in_tag_i;
    end
  end

  assign ds_busy_d = (ds_busy_q & ~ds_sample) | (issue & op_ds);

  // A fast issue can only happen when slot 0 is free, so at most one write per cycle.
  always_comb begin
    wr_en  = 1'b0;
    wr_res = '0;
    wr_tag = '0;
    wr_exc = '0;
    if (slot_q[0]) begin
      wr_en  = 1'b1;
      wr_tag = slot_tag_q[0];
      if (slot_src_q[0] == SrcDs) begin
        wr_res = ds_res_i;
        wr_exc = ds_exc_i;
      end else begin
        wr_res = mul_res_i;
        wr_exc = mul_exc_i;
      end
    end else if (issue && !op_slow) begin
      wr_en  = 1'b1;
      wr_tag = in_tag_i;
      wr_res = op_fixed ? fixed_res : fast_res_i;
      wr_exc = op_fixed ? fixed_exc : fast_exc_i;
    end
  end

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_res_o   = out_valid_o ? mem_res_q[rd_ptr_q] : '0;
  assign out_tag_o   = out_valid_o ? mem_tag_q[rd_ptr_q] : '0;
  assign out_exc_o   = out_valid_o ? mem_exc_q[rd_ptr_q] : '0;

  assign wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);

  // A clear in the same cycle as a pop keeps the popped flags.
  assign fsr_d = (fsr_clr_i ? 5'b0 : fsr_q) | (pop ? out_exc_o : 5'b0);

  assign fsr_o  = fsr_q;
  assign busy_o = (|slot_q) | ds_busy_q | out_valid_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_q    <= '0;
      ds_busy_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fsr_q     <= '0;
      for (int k = 0; k <= int'(LMAX); k++) begin
        slot_src_q[k] <= SrcMul;
        slot_tag_q[k] <= '0;
      end
    end else begin
      slot_q    <= slot_d;
      ds_busy_q <= ds_busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fsr_q     <= fsr_d;
      for (int k = 0; k <= int'(LMAX); k++) begin
        slot_src_q[k] <= slot_src_d[k];
        slot_tag_q[k] <= slot_tag_d[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_res_q[wr_ptr_q] <= wr_res;
      mem_tag_q[wr_ptr_q] <= wr_tag;
      mem_exc_q[wr_ptr_q] <= wr_exc;
    end
  end

endmodule

// File: tb/tb_fpu_sched.sv
// Directed self-checking bench for fpu_sched at default parameters.
module tb_fpu_sched;

  localparam logic [3:0] OP_FADD = 4'b0000;
  localparam logic [3:0] OP_FMUL = 4'b0010;
  localparam logic [3:0] OP_FDIV = 4'b0011;
  localparam logic [3:0] OP_SQRT = 4'b0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, in_a_sign, in_b_zero;
  logic [3:0]  in_op, in_tag, out_tag;
  logic [31:0] fast_res, mul_res, ds_res, out_res;
  logic [4:0]  fast_exc, mul_exc, ds_exc, out_exc, fsr;
  logic        ds_start, ds_is_sqrt, out_valid, out_ready, fsr_clr, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fpu_sched #(
    .TAG_W(4), .LAT_MUL(2), .LAT_DIV(3), .LAT_SQRT(2), .OUT_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op), .in_tag_i(in_tag),
    .in_a_sign_i(in_a_sign), .in_b_zero_i(in_b_zero),
    .fast_res_i(fast_res), .fast_exc_i(fast_exc),
    .mul_res_i(mul_res), .mul_exc_i(mul_exc),
    .ds_res_i(ds_res), .ds_exc_i(ds_exc),
    .ds_start_o(ds_start), .ds_is_sqrt_o(ds_is_sqrt),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_res_o(out_res), .out_tag_o(out_tag), .out_exc_o(out_exc),
    .fsr_clr_i(fsr_clr), .fsr_o(fsr), .busy_o(busy)
  );

  // Advance one cycle; unit buses carry a per-cycle signature so the sample cycle is visible.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    fast_res = 32'hF000_0000 | 32'(cyc);
    mul_res  = 32'hA000_0000 | 32'(cyc);
    ds_res   = 32'hD000_0000 | 32'(cyc);
    mul_exc  = 5'(cyc + 3);
    ds_exc   = 5'(cyc);
    fast_exc = 5'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1; fsr_clr = 1'b0; in_b_zero = 1'b0; in_a_sign = 1'b0;
    #1;
    while ((busy || out_valid) && n < 20) begin
      tick(); #1; n++;
    end
    total++;
    if (busy || out_valid) begin
      bad++; $display("FAIL drain_timeout: busy=%b out_valid=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    in_valid = 1'b1; in_op = OP_FADD; in_tag = 4'd1; #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++;
    if ({out_valid, ds_start, ds_is_sqrt, busy} !== 4'b0) begin
      bad++; $display("FAIL rst_ctrl: got v=%b ds=%b sq=%b busy=%b want 0", out_valid, ds_start,
                      ds_is_sqrt, busy);
    end
    total++;
    if (out_res !== 32'h0 || out_tag !== 4'h0 || out_exc !== 5'h0 || fsr !== 5'h0) begin
      bad++; $display("FAIL rst_data: got res=%h tag=%h exc=%b fsr=%b want 0", out_res, out_tag,
                      out_exc, fsr);
    end
    tick();
    rst_n = 1'b1; in_valid = 1'b0; #1;
  endtask

  task automatic test_back_to_back();
    int c0;
    tick(); c0 = cyc;
    in_valid = 1'b1; in_op = OP_FMUL; in_tag = 4'd1; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_issue1: in_ready=%b want 1", in_ready); end
    tick(); in_tag = 4'd2; #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_issue2: in_ready=%b busy=%b want 1/1", in_ready, busy);
    end
    tick(); in_tag = 4'd3; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_issue3: in_ready=%b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick(); in_valid = 1'b0; #1;
      total++;
      if (out_valid !== 1'b1 || out_tag !== 4'(i + 1) ||
          out_res !== (32'hA000_0000 | 32'(c0 + 2 + i)) || out_exc !== 5'(c0 + 2 + i + 3)) begin
        bad++; $display("FAIL b2b_out%0d: got v=%b tag=%h res=%h exc=%b want 1/%0d/%h/%b", i,
                        out_valid, out_tag, out_res, out_exc, i + 1,
                        32'hA000_0000 | 32'(c0 + 2 + i), 5'(c0 + 5 + i));
      end
    end
    tick(); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_slot_conflict();
    int c0;
    tick(); c0 = cyc;
    in_valid = 1'b1; in_op = OP_FDIV; in_tag = 4'd5; #1;
    total++;
    if (in_ready !== 1'b1 || ds_start !== 1'b1) begin
      bad++; $display("FAIL conf_div: in_ready=%b ds_start=%b want 1/1", in_ready, ds_start);
    end
    tick(); in_op = OP_FMUL; in_tag = 4'd6; #1;
    total++;
    if (in_ready !== 1'b0 || ds_start !== 1'b0) begin
      bad++; $display("FAIL conf_block: in_ready=%b ds_start=%b want 0/0", in_ready, ds_start);
    end
    tick(); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL conf_accept: in_ready=%b want 1", in_ready); end
    tick(); in_valid = 1'b0; #1;
    tick(); #1;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd5 || out_res !== (32'hD000_0000 | 32'(c0 + 3)) ||
        out_exc !== 5'(c0 + 3)) begin
      bad++; $display("FAIL conf_out5: got v=%b tag=%h res=%h exc=%b want 1/5/%h/%b", out_valid,
                      out_tag, out_res, out_exc, 32'hD000_0000 | 32'(c0 + 3), 5'(c0 + 3));
    end
    tick(); #1;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd6 || out_res !== (32'hA000_0000 | 32'(c0 + 4))) begin
      bad++; $display("FAIL conf_out6: got v=%b tag=%h res=%h want 1/6/%h", out_valid, out_tag,
                      out_res, 32'hA000_0000 | 32'(c0 + 4));
    end
  endtask

  task automatic test_ds_busy();
    int c0;
    tick(); c0 = cyc;
    in_valid = 1'b1; in_op = OP_FDIV; in_tag = 4'd7; #1;
    total++;
    if (in_ready !== 1'b1 || ds_start !== 1'b1 || ds_is_sqrt !== 1'b0) begin
      bad++; $display("FAIL dsb_first: rdy=%b start=%b sqrt=%b want 1/1/0", in_ready, ds_start,
                      ds_is_sqrt);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(); in_tag = 4'd8; #1;
      total++;
      if (in_ready !== (i == 3) || ds_start !== (i == 3)) begin
        bad++; $display("FAIL dsb_hold%0d: rdy=%b start=%b want %0d/%0d", i, in_ready, ds_start,
                        i == 3, i == 3);
      end
    end
    tick(); in_valid = 1'b0; #1;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd7 || out_res !== (32'hD000_0000 | 32'(c0 + 3))) begin
      bad++; $display("FAIL dsb_out7: got v=%b tag=%h res=%h want 1/7/%h", out_valid, out_tag,
                      out_res, 32'hD000_0000 | 32'(c0 + 3));
    end
    tick(); tick(); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL dsb_gap: out_valid=%b want 0", out_valid); end
    tick(); #1;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd8 || out_res !== (32'hD000_0000 | 32'(c0 + 6))) begin
      bad++; $display("FAIL dsb_out8: got v=%b tag=%h res=%h want 1/8/%h", out_valid, out_tag,
                      out_res, 32'hD000_0000 | 32'(c0 + 6));
    end
  endtask

  task automatic test_sqrt();
    int c0;
    tick(); c0 = cyc;
    in_valid = 1'b1; in_op = OP_SQRT; in_tag = 4'd9; #1;
    total++;
    if (in_ready !== 1'b1 || ds_start !== 1'b1 || ds_is_sqrt !== 1'b1) begin
      bad++; $display("FAIL sqrt_issue: rdy=%b start=%b sqrt=%b want 1/1/1", in_ready, ds_start,
                      ds_is_sqrt);
    end
    tick(); in_valid = 1'b0; tick(); tick(); #1;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd9 || out_res !== (32'hD000_0000 | 32'(c0 + 2))) begin
      bad++; $display("FAIL sqrt_out: got v=%b tag=%h res=%h want 1/9/%h", out_valid, out_tag,
                      out_res, 32'hD000_0000 | 32'(c0 + 2));
    end
  endtask

  task automatic test_credit();
    int c0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) c0 = cyc;
      in_valid = 1'b1; in_op = OP_FADD; in_tag = 4'(i + 1);
      if (i == 4) out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== (i < 4)) begin
        bad++; $display("FAIL credit_rdy%0d: in_ready=%b want %0d", i, in_ready, i < 4);
      end
    end
    total++;
    if (out_tag !== 4'd1 || out_res !== (32'hF000_0000 | 32'(c0))) begin
      bad++; $display("FAIL credit_head: tag=%h res=%h want 1/%h", out_tag, out_res,
                      32'hF000_0000 | 32'(c0));
    end
    tick(); out_ready = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1 || out_tag !== 4'd2) begin
      bad++; $display("FAIL credit_refill: in_ready=%b tag=%h want 1/2", in_ready, out_tag);
    end
    tick(); in_valid = 1'b0; out_ready = 1'b1; #1;
    for (int i = 2; i <= 5; i++) begin
      if (i > 2) begin tick(); #1; end
      total++;
      if (out_valid !== 1'b1 || out_tag !== 4'(i) ||
          (i == 5 && out_res !== (32'hF000_0000 | 32'(c0 + 5)))) begin
        bad++; $display("FAIL credit_pop%0d: v=%b tag=%h res=%h want 1/%0d", i, out_valid, out_tag,
                        out_res, i);
      end
    end
  endtask

  task automatic test_fsr();
    tick(); fsr_clr = 1'b1;
    tick(); fsr_clr = 1'b0;
    in_valid = 1'b1; in_op = OP_FADD; in_tag = 4'd1; fast_exc = 5'b00100; #1;
    total++;
    if (fsr !== 5'b0) begin bad++; $display("FAIL fsr_clr0: fsr=%b want 00000", fsr); end
    tick(); in_tag = 4'd2; fast_exc = 5'b00001; #1;
    total++;
    if (out_tag !== 4'd1 || out_exc !== 5'b00100) begin
      bad++; $display("FAIL fsr_head1: tag=%h exc=%b want 1/00100", out_tag, out_exc);
    end
    tick(); in_op = 4'b1101; in_tag = 4'd3; fast_exc = 5'b01010; #1;
    total++;
    if (fsr !== 5'b00100) begin bad++; $display("FAIL fsr_acc1: fsr=%b want 00100", fsr); end
    tick(); in_valid = 1'b0; fsr_clr = 1'b1; #1;
    total++;
    if (fsr !== 5'b00101) begin bad++; $display("FAIL fsr_acc2: fsr=%b want 00101", fsr); end
    total++;
    if (out_tag !== 4'd3 || out_res !== 32'h0 || out_exc !== 5'b10000) begin
      bad++; $display("FAIL fsr_reserved: tag=%h res=%h exc=%b want 3/0/10000", out_tag, out_res,
                      out_exc);
    end
    tick(); fsr_clr = 1'b0; #1;
    total++;
    if (fsr !== 5'b10000) begin bad++; $display("FAIL fsr_clr_pop: fsr=%b want 10000", fsr); end
  endtask

  task automatic test_early_exc();
    int c0;
    tick(); c0 = cyc;
    in_valid = 1'b1; in_op = OP_FDIV; in_tag = 4'd10; in_b_zero = 1'b1; #1;
`ifdef FPU_SCHED_EARLY_EXC_EN
    total++;
    if (in_ready !== 1'b1 || ds_start !== 1'b0) begin
      bad++; $display("FAIL early_issue: rdy=%b start=%b want 1/0", in_ready, ds_start);
    end
    tick(); in_valid = 1'b0; in_b_zero = 1'b0; #1;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd10 || out_res !== 32'h7FC0_0000 ||
        out_exc !== 5'b11000) begin
      bad++; $display("FAIL early_out: v=%b tag=%h res=%h exc=%b want 1/a/7fc00000/11000",
                      out_valid, out_tag, out_res, out_exc);
    end
`else
    total++;
    if (in_ready !== 1'b1 || ds_start !== 1'b1) begin
      bad++; $display("FAIL early_issue: rdy=%b start=%b want 1/1", in_ready, ds_start);
    end
    tick(); in_valid = 1'b0; in_b_zero = 1'b0; tick(); tick(); tick(); #1;
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd10 || out_res !== (32'hD000_0000 | 32'(c0 + 3)) ||
        out_exc !== 5'(c0 + 3)) begin
      bad++; $display("FAIL early_out: v=%b tag=%h res=%h exc=%b want 1/a/%h/%b", out_valid,
                      out_tag, out_res, out_exc, 32'hD000_0000 | 32'(c0 + 3), 5'(c0 + 3));
    end
`endif
  endtask

  task automatic test_mid_reset();
    tick();
    in_valid = 1'b1; in_op = OP_FDIV; in_tag = 4'd4; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_issue: in_ready=%b want 1", in_ready); end
    tick(); rst_n = 1'b0; in_op = OP_FADD; #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mrst_ready: in_ready=%b want 0", in_ready); end
    tick(); rst_n = 1'b1; in_valid = 1'b0; #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy: busy=%b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL mrst_ghost%0d: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = OP_FADD; in_tag = '0; in_a_sign = 1'b0;
    in_b_zero = 1'b0; fast_res = '0; fast_exc = '0; mul_res = '0; mul_exc = '0;
    ds_res = '0; ds_exc = '0; out_ready = 1'b1; fsr_clr = 1'b0;
    test_reset();
    drain();
    test_back_to_back();
    drain();
    test_slot_conflict();
    drain();
    test_ds_busy();
    drain();
    test_sqrt();
    drain();
    test_credit();
    drain();
    test_fsr();
    drain();
    test_early_exc();
    drain();
    test_mid_reset();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
